// File: rtl/reg_file.sv
// ---------------------------------------------------------------------------
// reg_file
//   Operand register file for the function unit. Eight (NREGS) W-bit general
//   registers, two combinational read ports (A/B), one write-back per cycle
//   through a single-entry pending register with read forwarding, and a Z/N
//   status register for the control sequencer.
//
// Ports
//   clk          system clock, all state changes on the rising edge
//   rst          asynchronous active-high reset
//   aa_in        port A read address
//   ba_in        port B read address
//   da_in        write destination address
//   rw_in        register write enable
//   d_in         write data (D bus)
//   st_ld_in     status load enable
//   z_in, n_in   zero / negative flags from the function unit
//   a_out, b_out combinational read data (forwarded from the pending entry)
//   z_out, n_out registered status flags
//   wb_busy_out  pending write-back entry holds an uncommitted write
// ---------------------------------------------------------------------------
module reg_file #(
    parameter int NREGS = 8,
    parameter int W     = 16,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] aa_in,
    input  logic [AW-1:0] ba_in,
    input  logic [AW-1:0] da_in,
    input  logic          rw_in,
    input  logic [W-1:0]  d_in,
    input  logic          st_ld_in,
    input  logic          z_in,
    input  logic          n_in,
    output logic [W-1:0]  a_out,
    output logic [W-1:0]  b_out,
    output logic          z_out,
    output logic          n_out,
    output logic          wb_busy_out
);

    logic [W-1:0]     reg_q [NREGS];
    logic             wb_v_q;
    logic [AW-1:0]    wb_a_q;
    logic [W-1:0]     wb_d_q;
    logic [NREGS-1:0] commit_en;

    // One-hot commit decode of the pending entry. Only wb_a_q (a registered,
    // qualified address) selects a register, so X on da_in while rw_in=0
    // can never reach the array.
    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_commit
            assign commit_en[gi] = wb_v_q && (wb_a_q == AW'(gi));
        end
    endgenerate

    // Register array: committed one edge after the write is captured.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                reg_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (commit_en[i]) begin
                    reg_q[i] <= wb_d_q;
                end
            end
        end
    end

    // Pending write-back entry. Address/data only load on a real write so
    // that idle cycles leave them untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_v_q <= 1'b0;
            wb_a_q <= '0;
            wb_d_q <= '0;
        end else begin
            wb_v_q <= rw_in;
            if (rw_in) begin
                wb_a_q <= da_in;
                wb_d_q <= d_in;
            end
        end
    end

    // Status register, independent of register writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z_out <= 1'b0;
            n_out <= 1'b0;
        end else if (st_ld_in) begin
            z_out <= z_in;
            n_out <= n_in;
        end
    end

    // Reads forward only from the pending entry, never from d_in, so there
    // is no combinational path from the D bus back to the operands.
    always_comb begin
        a_out = reg_q[aa_in];
        b_out = reg_q[ba_in];
        if (wb_v_q && (wb_a_q == aa_in)) begin
            a_out = wb_d_q;
        end
        if (wb_v_q && (wb_a_q == ba_in)) begin
            b_out = wb_d_q;
        end
    end

    assign wb_busy_out = wb_v_q;

endmodule

// File: tb/tb_reg_file.sv
// ---------------------------------------------------------------------------
// tb_reg_file
//   Self-checking bench for reg_file. The reference model keeps the
//   architectural register contents: a write issued in cycle t is visible
//   to reads from cycle t+1 on, regardless of where the DUT holds it.
//   Directed sequences with literal expectations pin the model, followed by
//   randomized traffic checked every cycle against the model.
// ---------------------------------------------------------------------------
module tb_reg_file;

    localparam int NREGS = 8;
    localparam int W     = 16;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] aa_in = '0;
    logic [AW-1:0] ba_in = '0;
    logic [AW-1:0] da_in = '0;
    logic          rw_in = 1'b0;
    logic [W-1:0]  d_in = '0;
    logic          st_ld_in = 1'b0;
    logic          z_in = 1'b0;
    logic          n_in = 1'b0;
    logic [W-1:0]  a_out;
    logic [W-1:0]  b_out;
    logic          z_out;
    logic          n_out;
    logic          wb_busy_out;

    int checks = 0;
    int errors = 0;

    reg_file #(.NREGS(NREGS), .W(W), .AW(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .aa_in       (aa_in),
        .ba_in       (ba_in),
        .da_in       (da_in),
        .rw_in       (rw_in),
        .d_in        (d_in),
        .st_ld_in    (st_ld_in),
        .z_in        (z_in),
        .n_in        (n_in),
        .a_out       (a_out),
        .b_out       (b_out),
        .z_out       (z_out),
        .n_out       (n_out),
        .wb_busy_out (wb_busy_out)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [W-1:0] mdl_mem [NREGS];
    logic         mdl_z;
    logic         mdl_n;
    logic         mdl_busy;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) mdl_mem[i] = '0;
            mdl_z    = 1'b0;
            mdl_n    = 1'b0;
            mdl_busy = 1'b0;
        end else begin
            if (rw_in) mdl_mem[da_in] = d_in;
            if (st_ld_in) begin
                mdl_z = z_in;
                mdl_n = n_in;
            end
            mdl_busy = rw_in;
        end
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            chk("model_a", a_out, mdl_mem[aa_in]);
            chk("model_b", b_out, mdl_mem[ba_in]);
            chk("model_z", {15'd0, z_out}, {15'd0, mdl_z});
            chk("model_n", {15'd0, n_out}, {15'd0, mdl_n});
            chk("model_busy", {15'd0, wb_busy_out}, {15'd0, mdl_busy});
        end
    end

    // Drive the inputs for the next cycle just after the rising edge.
    task automatic drive(input logic rw, input logic [AW-1:0] da, input logic [W-1:0] d,
                         input logic [AW-1:0] aa, input logic [AW-1:0] ba,
                         input logic st, input logic z, input logic n);
        @(posedge clk);
        #1;
        rw_in = rw; da_in = da; d_in = d;
        aa_in = aa; ba_in = ba;
        st_ld_in = st; z_in = z; n_in = n;
    endtask

    task automatic idle(input logic [AW-1:0] aa, input logic [AW-1:0] ba);
        drive(1'b0, 3'd0, 16'h0000, aa, ba, 1'b0, 1'b0, 1'b0);
    endtask

    logic [AW-1:0] last_da;
    logic [AW-1:0] ra;
    logic [AW-1:0] rb;

    initial begin
        // Reset state
        #12;
        chk("reset_a", a_out, 16'h0000);
        chk("reset_busy", {15'd0, wb_busy_out}, 16'h0000);
        @(posedge clk); #1; rst = 1'b0;

        // Reset asynchronously after writing R3
        drive(1'b1, 3'd3, 16'h1234, 3'd3, 3'd3, 1'b1, 1'b1, 1'b1);
        idle(3'd3, 3'd3);
        #3;
        chk("r3_fwd", a_out, 16'h1234);
        idle(3'd3, 3'd3);
        #1; rst = 1'b1; #1;
        chk("async_rst_a", a_out, 16'h0000);
        chk("async_rst_z", {15'd0, z_out}, 16'h0000);
        chk("async_rst_n", {15'd0, n_out}, 16'h0000);
        chk("async_rst_busy", {15'd0, wb_busy_out}, 16'h0000);
        #1; rst = 1'b0;

        // Basic write/read
        drive(1'b1, 3'd5, 16'hBEEF, 3'd5, 3'd0, 1'b0, 1'b0, 1'b0);
        #3; chk("wr_c0_old", a_out, 16'h0000);
        idle(3'd5, 3'd0);
        #3; chk("wr_c1_fwd", a_out, 16'hBEEF);
        chk("wr_c1_busy", {15'd0, wb_busy_out}, 16'h0001);
        idle(3'd5, 3'd0);
        #3; chk("wr_c2_arr", a_out, 16'hBEEF);
        chk("wr_c2_busy", {15'd0, wb_busy_out}, 16'h0000);

        // Back-to-back same address
        drive(1'b1, 3'd2, 16'h0001, 3'd0, 3'd2, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 3'd2, 16'h0002, 3'd0, 3'd2, 1'b0, 1'b0, 1'b0);
        #3; chk("b2b_c1", b_out, 16'h0001);
        for (int c = 2; c < 5; c++) begin
            idle(3'd0, 3'd2);
            #3; chk("b2b_later", b_out, 16'h0002);
        end

        // Interleaved addresses
        drive(1'b1, 3'd1, 16'hAAAA, 3'd1, 3'd7, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 3'd7, 16'h5555, 3'd1, 3'd7, 1'b0, 1'b0, 1'b0);
        idle(3'd1, 3'd7);
        #3; chk("ilv_a", a_out, 16'hAAAA);
        chk("ilv_b", b_out, 16'h5555);
        idle(3'd7, 3'd7);
        #3; chk("same_addr_a", a_out, 16'h5555);
        chk("same_addr_b", b_out, 16'h5555);

        // Status register
        drive(1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1);
        #3; chk("st_c1_z", {15'd0, z_out}, 16'h0001);
        chk("st_c1_n", {15'd0, n_out}, 16'h0000);
        idle(3'd0, 3'd0);
        #3; chk("st_c2_z", {15'd0, z_out}, 16'h0001);
        chk("st_c2_n", {15'd0, n_out}, 16'h0000);
        drive(1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1);
        idle(3'd0, 3'd0);
        #3; chk("st_c4_z", {15'd0, z_out}, 16'h0000);
        chk("st_c4_n", {15'd0, n_out}, 16'h0001);

        // Reset during a pending write
        drive(1'b1, 3'd4, 16'hFFFF, 3'd4, 3'd4, 1'b0, 1'b0, 1'b0);
        idle(3'd4, 3'd4);
        #1; rst = 1'b1; #2; rst = 1'b0;
        idle(3'd4, 3'd4);
        #3; chk("rst_wr_r4", a_out, 16'h0000);
        chk("rst_wr_busy", {15'd0, wb_busy_out}, 16'h0000);
        chk("rst_wr_r5", {15'd0, wb_busy_out}, {15'd0, mdl_busy});

        // Randomized traffic, checked every cycle by the compare process
        last_da = 3'd0;
        for (int k = 0; k < 400; k++) begin
            ra = ($urandom_range(0, 1) == 0) ? last_da : AW'($urandom_range(0, NREGS - 1));
            rb = ($urandom_range(0, 3) == 0) ? ra : AW'($urandom_range(0, NREGS - 1));
            drive(($urandom_range(0, 3) != 0), AW'($urandom_range(0, NREGS - 1)),
                  W'($urandom), ra, rb, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            last_da = da_in;
            if ($urandom_range(0, 63) == 0) begin
                #1; rst = 1'b1; #1; rst = 1'b0;
            end
        end
        idle(3'd0, 3'd0);
        idle(3'd0, 3'd0);
        #3;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file.md
# reg_file

Operand register file feeding the function unit. Holds eight 16-bit general registers and drives the unit's A and B operands from two combinational read ports. Accepts one write-back per cycle of the function unit result (or other D-bus data) through a one-entry write-back pipeline register with read forwarding. Also latches the unit's Z/N status flags into a status register for the control sequencer.

## Interface
Parameters:
- `NREGS`, 8: number of registers; must be a power of two.
- `W`, 16: data width.
- `AW`, $clog2(NREGS) = 3: register address width.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `aa_in`  in  AW  read address, port A.
- `ba_in`  in  AW  read address, port B.
- `da_in`  in  AW  write destination address.
- `rw_in`  in  1  register write enable.
- `d_in`  in  W  write data (D bus).
- `st_ld_in`  in  1  status load enable.
- `z_in`  in  1  zero flag from the function unit.
- `n_in`  in  1  negative flag from the function unit.
- `a_out`  out  W  port A read data, combinational.
- `b_out`  out  W  port B read data, combinational.
- `z_out`  out  1  registered zero flag.
- `n_out`  out  1  registered negative flag.
- `wb_busy_out`  out  1  high while the write-back register holds an uncommitted write.

## Operation
- Storage: `reg_q[0..NREGS-1]`, each W bits, all writable; no hard-wired zero register.
- Write-back register: `wb_v_q`, `wb_a_q`, `wb_d_q`.
- Each edge: if `wb_v_q`, commit `reg_q[wb_a_q] <= wb_d_q`. Then `wb_v_q <= rw_in`; if `rw_in`, also `wb_a_q <= da_in` and `wb_d_q <= d_in`.
- Read A: if `wb_v_q && wb_a_q == aa_in`, `a_out = wb_d_q`; else `a_out = reg_q[aa_in]`. Read B is identical with `ba_in`.
- Forwarding is from the pending entry only. Data on `d_in` in the current cycle is never visible on `a_out`/`b_out` in that same cycle. This prevents a comb loop through the function unit.
- Status register: on an edge with `st_ld_in=1`, `z_out <= z_in` and `n_out <= n_in`; otherwise both hold. It is independent of `rw_in`.
- `wb_busy_out = wb_v_q`.
- X on addresses while `rw_in=0` must not corrupt state.

## Timing
- Reset, asynchronous: all `reg_q` = 0; `wb_v_q` = 0; `wb_a_q` = 0; `wb_d_q` = 0; `z_out` = 0; `n_out` = 0; `wb_busy_out` = 0. While reset is high, `a_out` and `b_out` therefore read 0.
- Reset asserted mid-operation discards any pending write. The write is not committed.
- Write latency: with `rw_in=1` in cycle t, the data is readable via forwarding from cycle t+1 and resides in the array from cycle t+2.
- Back-to-back writes to the same address in cycles t and t+1:
  - Edge t+1 commits the first write; the second becomes pending.
  - Cycle t+2 reads the second value.
  - The array holds the second value from cycle t+3.
- Write in cycle t+1 to a different address than the one pending: both values are readable in cycle t+2, one from the array and one forwarded.
- `aa_in == ba_in`: both ports return the same value.
- Status flags appear on `z_out`/`n_out` one cycle after the `st_ld_in` cycle.
- Throughput: one write per cycle with no stall. `wb_busy_out` is informational only.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle after writing R3=0x1234 -> `a_out`=0 with `aa_in`=3 immediately; all flags 0; `wb_busy_out`=0.
- Basic write/read: cycle 0 `rw_in`=1, `da_in`=5, `d_in`=0xBEEF; `aa_in`=5 -> cycle 0 `a_out`=0 (old value); cycle 1 `a_out`=0xBEEF (forwarded, `wb_busy_out`=1); cycle 2 `a_out`=0xBEEF (array, `wb_busy_out`=0).
- Back-to-back same address: R2 <= 0x0001 at cycle 0, R2 <= 0x0002 at cycle 1; `ba_in`=2 -> `b_out` = 0x0001 at cycle 1 and 0x0002 from cycle 2 onward; never 0x0001 after cycle 1.
- Interleaved addresses: writes R1=0xAAAA at cycle 0 and R7=0x5555 at cycle 1; `aa_in`=1, `ba_in`=7 -> cycle 2 `a_out`=0xAAAA and `b_out`=0x5555.
- Status register: `st_ld_in`=1 with `z_in`=1, `n_in`=0 at cycle 0, then `st_ld_in`=0 with `z_in`=0, `n_in`=1 at cycle 1 -> `z_out`=1 and `n_out`=0 in cycles 1 and 2; a load at cycle 3 with `z_in`=0, `n_in`=1 gives `z_out`=0 and `n_out`=1 at cycle 4.
- Reset mid-write: `rw_in`=1, `da_in`=4, `d_in`=0xFFFF at cycle 0; `rst` pulse during cycle 1 -> R4 reads 0 after reset; `wb_busy_out`=0.
